// File: rtl/convolution_processor_tap_line.sv
// Tapped delay line feeding the MAC array. It holds the last DEPTH samples,
// presents them as one flattened window over a valid/ready handshake, tracks
// the fill level and can rotate a full, idle window in place for kernel reuse.
module convolution_processor_tap_line #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clrh,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          rot_en,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [DEPTH*DATA_WIDTH-1:0]   win_data,
  output logic [CNT_W-1:0]              fill_cnt,
  output logic                          full
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] taps [DEPTH];
  logic                  accept;
  logic                  consume;
  logic                  rotate;
  logic                  clear;
  logic [CNT_W-1:0]      fill_nxt;
  logic                  win_valid_nxt;

  // Handshake strobes and the accept > rotate > clear arbitration.
  // A rotation only happens on an idle full window, so the window being
  // rotated is never one that downstream still has to consume.
  always_comb begin
    in_ready = ~win_valid | win_ready;
    accept   = in_valid & in_ready;
    consume  = win_valid & win_ready;
    rotate   = rot_en & ~accept & full & ~win_valid;
    clear    = clrh & ~accept & ~rotate;
  end

  // Next fill level: saturate at DEPTH so the counter never wraps.
  always_comb begin
    fill_nxt = fill_cnt;
    if (accept) begin
      if (fill_cnt == DEPTH_CNT) fill_nxt = DEPTH_CNT;
      else                       fill_nxt = fill_cnt + CNT_W'(1);
    end else if (clear) begin
      fill_nxt = '0;
    end
  end

  // Next window-valid state. A new sample that completes the window re-arms
  // valid even when the previous window is consumed in the same cycle, which
  // is what gives bubble-free streaming once the line is full.
  always_comb begin
    win_valid_nxt = win_valid;
    if (clear)                                 win_valid_nxt = 1'b0;
    else if (accept && fill_nxt == DEPTH_CNT)  win_valid_nxt = 1'b1;
    else if (rotate)                           win_valid_nxt = 1'b1;
    else if (consume)                          win_valid_nxt = 1'b0;
  end

  // Tap storage: shift in on accept, circular shift on rotate, zero on clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (accept) begin
      taps[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end else if (rotate) begin
      taps[0] <= taps[DEPTH-1];
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end
  end

  // Control state: fill level and window-valid flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_cnt  <= '0;
      win_valid <= 1'b0;
    end else begin
      fill_cnt  <= fill_nxt;
      win_valid <= win_valid_nxt;
    end
  end

  // Flatten the taps onto the window bus, tap 0 (newest) in the low lane.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < DEPTH; i++) win_data[i*DATA_WIDTH +: DATA_WIDTH] = taps[i];
  end

  // Full flag is purely a decode of the registered fill level.
  always_comb begin
    full = (fill_cnt == DEPTH_CNT);
  end

endmodule

// File: tb/tb_convolution_processor_tap_line.sv
// Directed bench for the tap line (DATA_WIDTH=8, DEPTH=4): a table of
// per-cycle stimulus with hand-computed expected outputs, plus hand-written
// sequences for reset behaviour.
module tb_convolution_processor_tap_line;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic               clk;
  logic               rstn;
  logic               clrh;
  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      in_data;
  logic               rot_en;
  logic               win_valid;
  logic               win_ready;
  logic [DP*DW-1:0]   win_data;
  logic [CW-1:0]      fill_cnt;
  logic               full;

  int total;
  int bad;

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        rot;
    logic        clr;
    logic        wr;
    logic [31:0] wd;
    logic        wv;
    logic [2:0]  fc;
    logic        fl;
    logic        ir;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  convolution_processor_tap_line #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clrh     (clrh),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rot_en   (rot_en),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .fill_cnt (fill_cnt),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] wd, input logic wv,
                           input logic [2:0] fc, input logic fl, input logic ir);
    check({tag, "_win_data"},  win_data,         wd);
    check({tag, "_win_valid"}, {31'd0, win_valid}, {31'd0, wv});
    check({tag, "_fill_cnt"},  {29'd0, fill_cnt},  {29'd0, fc});
    check({tag, "_full"},      {31'd0, full},      {31'd0, fl});
    check({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, ir});
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic rot,
                       input logic clr, input logic wr);
    in_valid  = iv;
    in_data   = id;
    rot_en    = rot;
    clrh      = clr;
    win_ready = wr;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //          iv    id     rot   clr   wr    win_data      wv    fc    fl    ir
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h00000011, 1'b0, 3'd1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h00001122, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 32'h00112233, 1'b0, 3'd3, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 32'h11223344, 1'b1, 3'd4, 1'b1, 1'b0};
    // 0x55 pending under backpressure: not accepted
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 32'h11223344, 1'b1, 3'd4, 1'b1, 1'b0};
    // streaming: consume + accept each cycle
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h22334455, 1'b1, 3'd4, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 32'h33445566, 1'b1, 3'd4, 1'b1, 1'b1};
    // consume only
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h33445566, 1'b0, 3'd4, 1'b1, 1'b1};
    // rotate idle full window
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h44556633, 1'b1, 3'd4, 1'b1, 1'b0};
    // rotate ignored while window pending
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h44556633, 1'b1, 3'd4, 1'b1, 1'b0};
    // clear loses to accept
    vecs[10] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 32'h55663377, 1'b1, 3'd4, 1'b1, 1'b1};
    // clear alone discards pending window
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b1};
    // partial fill, rotate ignored when not full
    vecs[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 32'h000000AA, 1'b0, 3'd1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 32'h0000AABB, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000AABB, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0000AABB, 1'b0, 3'd2, 1'b0, 1'b1};
    // clear a partial line, refill, consume, rotate
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h00000011, 1'b0, 3'd1, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h00001122, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 32'h00112233, 1'b0, 3'd3, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 32'h11223344, 1'b1, 3'd4, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b0, 3'd4, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h22334411, 1'b1, 3'd4, 1'b1, 1'b0};
    // rotate loses to accept in the same cycle
    vecs[23] = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 32'h33441199, 1'b1, 3'd4, 1'b1, 1'b1};
    // clear with a pending window and no accept
    vecs[24] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b1};

    // reset state
    rstn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #12;
    check_all("reset", 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    rstn = 1'b1;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].id, vecs[i].rot, vecs[i].clr, vecs[i].wr);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].wd, vecs[i].wv, vecs[i].fc, vecs[i].fl, vecs[i].ir);
    end

    // fill wrap: stream 6 samples, counter saturates and old samples fall off
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    check_all("wrap", 32'hC2C3C4C5, 1'b1, 3'd4, 1'b1, 1'b1);

    // asynchronous reset mid-stream, between clock edges
    @(negedge clk);
    drive(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("post_rst", 32'h0000005A, 1'b0, 3'd1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
